// File: rtl/irs_readout_scheduler.sv
// irs_readout_scheduler: sequences block readout across up to four IRS stacks.
// Starts each selected stack's readout controller in ascending order and
// merges the per-stack data streams into one tagged output stream.
// Optional build macro IRS_READOUT_TIMEOUT_EN adds a per-stack watchdog that
// aborts a stalled controller and flags err_o.
module irs_readout_scheduler #(
   parameter int unsigned NUM_STACKS     = 4,
   parameter int unsigned RELEASE_CYCLES = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     req_i,
   input  logic [NUM_STACKS-1:0]    stack_mask_i,
   input  logic [7:0]               ch_mask_i,
   output logic                     busy_o,
   output logic                     ack_o,
   output logic                     err_o,
   output logic [NUM_STACKS-1:0]    rd_start_o,
   output logic [7:0]               rd_ch_sel_o,
   input  logic [12*NUM_STACKS-1:0] rd_dat_i,
   input  logic [NUM_STACKS-1:0]    rd_valid_i,
   input  logic [NUM_STACKS-1:0]    rd_done_i,
   output logic [11:0]              dat_o,
   output logic [1:0]               stack_o,
   output logic                     valid_o,
   output logic                     last_o
);

   if (NUM_STACKS < 1 || NUM_STACKS > 4 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("irs_readout_scheduler: illegal NUM_STACKS or TIMEOUT_CYCLES");
   end

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SELECT  = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   logic [2:0]            state;
   logic [NUM_STACKS-1:0] pend;
   logic [7:0]            chm;
   logic [1:0]            k_q;
   logic [1:0]            low_k;
   logic [NUM_STACKS-1:0] k_onehot;
   logic [15:0]           rel_cnt;
   logic                  sel_valid;
   logic                  sel_done;
   logic [11:0]           sel_dat;
   logic                  abort;

   assign rd_ch_sel_o = chm;

   // Lowest pending stack, and the input lanes of the stack currently served
   always_comb begin
      low_k     = '0;
      k_onehot  = '0;
      sel_valid = 1'b0;
      sel_done  = 1'b0;
      sel_dat   = '0;
      for (int unsigned i = NUM_STACKS; i > 0; i--) begin
         if (pend[i-1]) low_k = 2'(i-1);
      end
      for (int unsigned i = 0; i < NUM_STACKS; i++) begin
         if (2'(i) == k_q) begin
            k_onehot[i] = 1'b1;
            sel_valid   = rd_valid_i[i];
            sel_done    = rd_done_i[i];
            sel_dat     = rd_dat_i[12*i +: 12];
         end
      end
   end

`ifdef IRS_READOUT_TIMEOUT_EN
   logic [15:0] wdog;

   // A valid word in the same cycle as expiry keeps the stack alive
   assign abort = (state == S_WAIT) && !sel_valid && (wdog == 16'(TIMEOUT_CYCLES));

   // Watchdog: clocks since the stack was started or last delivered a word
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wdog <= '0;
      end else if (state == S_START) begin
         wdog <= '0;
      end else if (state == S_WAIT) begin
         if (sel_valid)                         wdog <= '0;
         else if (wdog != 16'(TIMEOUT_CYCLES))  wdog <= wdog + 16'd1;
      end
   end

   // Sticky error flag, cleared when the next request is accepted
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                        err_o <= 1'b0;
      else if (state == S_IDLE && req_i)   err_o <= 1'b0;
      else if (abort)                      err_o <= 1'b1;
   end
`else
   assign abort = 1'b0;
   assign err_o = 1'b0;
`endif

   // Request sequencing: one start at a time, lowest stack first
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= S_IDLE;
         pend       <= '0;
         chm        <= '0;
         k_q        <= '0;
         rel_cnt    <= '0;
         busy_o     <= 1'b0;
         ack_o      <= 1'b0;
         rd_start_o <= '0;
      end else begin
         ack_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_i) begin
                  pend   <= stack_mask_i;
                  chm    <= ch_mask_i;
                  busy_o <= 1'b1;
                  if (stack_mask_i == '0 || ch_mask_i == '0) begin
                     state <= S_FINISH;
                     ack_o <= 1'b1;
                  end else begin
                     state <= S_SELECT;
                  end
               end
            end
            S_SELECT: begin
               k_q   <= low_k;
               state <= S_START;
            end
            S_START: begin
               rd_start_o <= k_onehot;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if ((sel_valid && sel_done) || abort) begin
                  pend       <= pend & ~k_onehot;
                  rd_start_o <= '0;
                  rel_cnt    <= '0;
                  state      <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (32'(rel_cnt) + 32'd1 >= RELEASE_CYCLES) begin
                  if (pend != '0) begin
                     state <= S_SELECT;
                  end else begin
                     state <= S_FINISH;
                     ack_o <= 1'b1;
                  end
               end else begin
                  rel_cnt <= rel_cnt + 16'd1;
               end
            end
            S_FINISH: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Registered merge of the served stack's words; last only on the final stack's done
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         dat_o   <= '0;
         stack_o <= '0;
      end else begin
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         if (state == S_WAIT && sel_valid) begin
            valid_o <= 1'b1;
            dat_o   <= sel_dat;
            stack_o <= k_q;
            last_o  <= sel_done && (pend == k_onehot);
         end
      end
   end

endmodule

// File: tb/tb_irs_readout_scheduler.sv
// Bench for irs_readout_scheduler: behavioural controller models plus a
// queue-based expectation of the merged output stream.
module tb_irs_readout_scheduler;
   localparam int NS = 4;
   localparam int TO = 100;

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic              req_i = 1'b0;
   logic [NS-1:0]     stack_mask_i = '0;
   logic [7:0]        ch_mask_i = '0;
   logic              busy_o, ack_o, err_o;
   logic [NS-1:0]     rd_start_o;
   logic [7:0]        rd_ch_sel_o;
   logic [12*NS-1:0]  rd_dat_i = '0;
   logic [NS-1:0]     rd_valid_i = '0;
   logic [NS-1:0]     rd_done_i = '0;
   logic [11:0]       dat_o;
   logic [1:0]        stack_o;
   logic              valid_o, last_o;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [11:0] d;
      logic [1:0]  s;
      logic        l;
   } word_t;

   word_t         exp_q[$];
   int            start_q[$];
   int            stall_s = -1;
   bit            spur = 1'b0;
   logic [NS-1:0] cur_mask = '0;
   logic [7:0]    cur_chm = '0;
   int            ack_cnt = 0;

   always #5 clk_i = ~clk_i;

   irs_readout_scheduler #(
      .NUM_STACKS(NS),
      .RELEASE_CYCLES(2),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i),
      .stack_mask_i(stack_mask_i), .ch_mask_i(ch_mask_i),
      .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o),
      .rd_start_o(rd_start_o), .rd_ch_sel_o(rd_ch_sel_o),
      .rd_dat_i(rd_dat_i), .rd_valid_i(rd_valid_i), .rd_done_i(rd_done_i),
      .dat_o(dat_o), .stack_o(stack_o), .valid_o(valid_o), .last_o(last_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] nth_ch(input logic [7:0] c, input int n);
      int seen = 0;
      nth_ch = '0;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) begin
            if (seen == n) nth_ch = 3'(i);
            seen++;
         end
      end
   endfunction

   // Expected stream: stacks ascending, channels ascending, 64 samples each
   function automatic void build(input logic [NS-1:0] m, input logic [7:0] c);
      int    last_s = -1;
      int    last_c = -1;
      word_t w;
      if (m == '0 || c == '0) return;
      for (int s = 0; s < NS; s++) if (m[s]) last_s = s;
      for (int ch = 0; ch < 8; ch++) if (c[ch]) last_c = ch;
      for (int s = 0; s < NS; s++) begin
         if (m[s]) begin
            start_q.push_back(s);
            for (int ch = 0; ch < 8; ch++) begin
               if (c[ch]) begin
                  for (int smp = 0; smp < 64; smp++) begin
                     w.d = {1'b0, 2'(s), 3'(ch), 6'(smp)};
                     w.s = 2'(s);
                     w.l = (s == last_s) && (ch == last_c) && (smp == 63) && (s != stall_s);
                     exp_q.push_back(w);
                  end
               end
            end
         end
      end
   endfunction

   // Readout controller models: answer a rising start with 64 words per channel
   initial begin : ctrl
      int cnt[NS];
      bit act[NS];
      bit armed[NS];
      int tot;
      for (int s = 0; s < NS; s++) begin
         cnt[s] = 0; act[s] = 1'b0; armed[s] = 1'b1;
      end
      forever begin
         @(posedge clk_i);
         #1;
         for (int s = 0; s < NS; s++) begin
            rd_valid_i[s] = 1'b0;
            rd_done_i[s]  = 1'b0;
            if (!rst_n_i) begin
               act[s] = 1'b0; armed[s] = 1'b1;
               continue;
            end
            if (!rd_start_o[s]) begin
               act[s] = 1'b0; armed[s] = 1'b1;
            end else if (armed[s]) begin
               act[s] = 1'b1; armed[s] = 1'b0; cnt[s] = 0;
            end
            tot = 64 * $countones(rd_ch_sel_o);
            if (act[s] && cnt[s] < tot && $urandom_range(3) != 0) begin
               rd_dat_i[12*s +: 12] = {1'b0, 2'(s), nth_ch(rd_ch_sel_o, cnt[s] / 64), 6'(cnt[s] % 64)};
               rd_valid_i[s] = 1'b1;
               rd_done_i[s]  = (cnt[s] == tot - 1) && (s != stall_s);
               cnt[s]++;
               if (rd_done_i[s]) act[s] = 1'b0;
            end else if (spur && !cur_mask[s] && $urandom_range(1) == 1) begin
               rd_dat_i[12*s +: 12] = 12'($urandom);
               rd_valid_i[s] = 1'b1;
               rd_done_i[s]  = 1'($urandom);
            end
         end
      end
   end

   // Output monitor: stream order, start protocol, channel select
   initial begin : mon
      word_t         w;
      int            s;
      int            gap = 100;
      logic [NS-1:0] prev_start = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            prev_start = '0; gap = 100;
            continue;
         end
         if (ack_o) ack_cnt++;
         if (valid_o) begin
            if (exp_q.size() == 0) begin
               chk("valid_none_expected", valid_o, 0);
            end else begin
               w = exp_q.pop_front();
               chk("dat", dat_o, w.d);
               chk("stack", stack_o, w.s);
               chk("last", last_o, w.l);
            end
         end else begin
            chk("last_without_valid", last_o, 0);
         end
         if (rd_start_o != '0 && prev_start == '0) begin
            chk("start_onehot", $countones(rd_start_o), 1);
            chk("start_gap_ge2", gap >= 2, 1);
            if (start_q.size() == 0) begin
               chk("start_none_expected", rd_start_o, 0);
            end else begin
               s = start_q.pop_front();
               chk("start_stack", rd_start_o, 32'(1) << s);
            end
         end else if (rd_start_o != '0) begin
            chk("start_stable", rd_start_o, prev_start);
         end
         if (busy_o) chk("ch_sel", rd_ch_sel_o, cur_chm);
         gap = (rd_start_o == '0) ? gap + 1 : 0;
         prev_start = rd_start_o;
      end
   end

   task automatic run_req(input logic [NS-1:0] m, input logic [7:0] c,
                          input bit inject, input bit exp_err);
      int            a0;
      int            bcycles = 0;
      int            first = -1;
      logic [NS-1:0] first_oh = '0;
      build(m, c);
      cur_mask = m;
      cur_chm  = c;
      for (int s = NS - 1; s >= 0; s--) if (m[s]) first = s;
      if (first >= 0 && c != 0) first_oh[first] = 1'b1;
      a0 = ack_cnt;
      @(posedge clk_i); #1;
      req_i = 1'b1; stack_mask_i = m; ch_mask_i = c;
      @(posedge clk_i); #1;
      req_i = 1'b0; stack_mask_i = NS'($urandom); ch_mask_i = 8'($urandom);
      chk("busy_after_accept", busy_o, 1);
      chk("err_clear_on_accept", err_o, 0);
      bcycles = 1;
      @(posedge clk_i); #1;
      if (busy_o) bcycles++;
      chk("no_start_after_edge1", rd_start_o, 0);
      @(posedge clk_i); #1;
      if (busy_o) bcycles++;
      chk("start_after_edge2", rd_start_o, first_oh);
      for (int i = 0; i < 20000 && busy_o; i++) begin
         if (inject && i == 40) begin
            req_i = 1'b1; stack_mask_i = ~m; ch_mask_i = ~c;
         end
         if (inject && i == 42) req_i = 1'b0;
         @(posedge clk_i); #1;
         if (busy_o) bcycles++;
      end
      chk("busy_drops", busy_o, 0);
      repeat (3) @(posedge clk_i);
      #1;
      chk("ack_once", ack_cnt - a0, 1);
      chk("words_left", exp_q.size(), 0);
      chk("starts_left", start_q.size(), 0);
      chk("err_after_req", err_o, exp_err);
      if (m == '0 || c == '0) chk("empty_busy_le3", bcycles <= 3, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [NS-1:0] m;
      logic [7:0]    c;
      int            a0;
      #12;
      chk("rst_busy", busy_o, 0);
      chk("rst_ack", ack_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_start", rd_start_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_ch_sel", rd_ch_sel_o, 0);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;

      run_req(4'b1111, 8'h01, 0, 0);
      run_req(4'b1010, 8'h81, 0, 0);
      run_req(4'b1111, 8'h00, 0, 0);
      run_req(4'b0000, 8'hFF, 0, 0);
      spur = 1'b1;
      run_req(4'b0101, 8'h24, 1, 0);
      spur = 1'b0;
      for (int n = 0; n < 3; n++) begin
         m = NS'($urandom);
         c = 8'(1 << $urandom_range(7)) | 8'(1 << $urandom_range(7));
         run_req(m, c, 0, 0);
      end

      // Reset while stack 2 is being read
      build(4'b1111, 8'h01);
      cur_mask = 4'b1111; cur_chm = 8'h01;
      @(posedge clk_i); #1;
      req_i = 1'b1; stack_mask_i = 4'b1111; ch_mask_i = 8'h01;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      for (int i = 0; i < 5000 && !rd_start_o[2]; i++) begin
         @(posedge clk_i); #1;
      end
      chk("reach_stack2", rd_start_o[2], 1);
      repeat (10) @(posedge clk_i);
      #3;
      a0 = ack_cnt;
      rst_n_i = 1'b0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_ack", ack_o, 0);
      chk("arst_start", rd_start_o, 0);
      chk("arst_ch_sel", rd_ch_sel_o, 0);
      chk("arst_dat", dat_o, 0);
      chk("arst_stack", stack_o, 0);
      chk("arst_valid", valid_o, 0);
      chk("arst_last", last_o, 0);
      exp_q.delete();
      start_q.delete();
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      chk("no_ack_after_reset", ack_cnt - a0, 0);
      run_req(4'b1101, 8'h03, 0, 0);

`ifdef IRS_READOUT_TIMEOUT_EN
      stall_s = 1;
      run_req(4'b1110, 8'h01, 0, 1);
      stall_s = -1;
      run_req(4'b0011, 8'h01, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irs_readout_scheduler.md
Name: irs_readout_scheduler

Overview:
- Sequences block readout across up to four IRS stacks. Each stack has its own readout controller with a start/done handshake.
- Accepts a single readout request (stack mask + channel mask), drives each selected stack's start in ascending stack order, and merges the per-stack data streams into one tagged output stream.
- Sits between the event builder and the per-stack readout controllers.

Parameters:
- NUM_STACKS, 4, number of readout controllers served (legal 1..4).
- RELEASE_CYCLES, 2, idle cycles with all starts low after a stack completes, before the next start is asserted.
- TIMEOUT_CYCLES, 4096, watchdog limit in clocks without a selected valid (only with the optional feature; 16-bit counter).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous assert, active-low
- req_i  in  1  readout request; sampled only in IDLE
- stack_mask_i  in  NUM_STACKS  stacks to read; latched on request accept
- ch_mask_i  in  8  channel select; latched on request accept
- busy_o  out  1  request in progress
- ack_o  out  1  one-cycle pulse when the request completes
- err_o  out  1  timeout occurred during the last request (optional feature)
- rd_start_o  out  NUM_STACKS  one-hot start to the readout controllers
- rd_ch_sel_o  out  8  channel select to the controllers
- rd_dat_i  in  12*NUM_STACKS  packed controller data; stack k occupies [12k+11:12k]
- rd_valid_i  in  NUM_STACKS  controller data valid
- rd_done_i  in  NUM_STACKS  controller last word (coincident with valid)
- dat_o  out  12  merged data
- stack_o  out  2  stack index of dat_o
- valid_o  out  1  dat_o valid
- last_o  out  1  final word of the entire request

Behaviour:
- Reset (rst_n_i low, asynchronous): every output and register is 0, and the state is IDLE.
- Latched stack and channel masks are held until the request finishes; rd_ch_sel_o equals the latched channel mask.
- States: IDLE, SELECT, START, WAIT_DONE, RELEASE, FINISH.
- IDLE:
  - Input: req_i=1.
  - Action: latch both masks into pend (stack mask) and chm; clear err_o.
  - Next state: SELECT.
  - busy_o goes to 1 on the next cycle.
  - If pend==0 or chm==0, go straight to FINISH instead. No start is ever issued, because a controller with an empty channel mask never terminates.
- SELECT: k = lowest set bit of pend; next state START.
- START / WAIT_DONE:
  - START asserts rd_start_o[k] for one cycle; WAIT_DONE holds it.
  - Request timing: req_i sampled at edge 0; rd_start_o[k]=1 after edge 2.
  - WAIT_DONE exits on rd_valid_i[k] & rd_done_i[k]: clear pend[k], drop rd_start_o, go to RELEASE.
- RELEASE:
  - Count RELEASE_CYCLES clocks, giving the controller time to return to idle.
  - Then go to SELECT if pend!=0, else FINISH.
- FINISH: ack_o=1 for exactly one cycle; busy_o=0 from the next cycle; next state IDLE.
- req_i is ignored while busy_o=1. A request presented on the same edge as FINISH is not accepted; it is seen in IDLE one cycle later if still held.
- Data path (registered, 1-cycle latency):
  - valid_o <= rd_valid_i[k] while in WAIT_DONE; dat_o <= rd_dat_i slice k; stack_o <= k.
  - Valids from unselected stacks, or valids outside WAIT_DONE, are ignored.
- last_o = valid_o & (the word was rd_done_i[k]) & (pend had only bit k set). It is asserted on exactly one word per successful request.
- Words per stack: 64 × popcount(chm). The scheduler does not check this.
- Stack indices ≥ NUM_STACKS in stack_mask_i are masked off at latch.
- Reset mid-operation: all starts drop immediately and no ack_o is issued.

Optional Feature:
- IRS_READOUT_TIMEOUT_EN defined:
  - A 16-bit watchdog clears on entry to START and on each accepted selected valid.
  - In WAIT_DONE, when the watchdog reaches TIMEOUT_CYCLES: set err_o (sticky until the next accepted request), drop the start, clear pend[k], go to RELEASE. The sequence then continues with the remaining stacks.
  - last_o is never asserted for an aborted stack. If the aborted stack was the final one, the request ends with ack_o but without last_o.
- IRS_READOUT_TIMEOUT_EN undefined: no watchdog; err_o is tied to 0; WAIT_DONE waits indefinitely.

Test Plan:
- stack_mask=4'b1111, ch_mask=8'h01; controllers in test mode.
  - Required: 256 words with stack_o sequence 0,1,2,3; each stack's data is {0,stack,3'd0,smp 0..63}.
  - Required: last_o only on word 256, then a single ack_o; starts never overlap; ≥2 idle cycles between them.
- stack_mask=4'b1010, ch_mask=8'h81.
  - Required: only stacks 1 then 3 started; 128 words each; channels 0 and 7; last_o on stack 3 smp 63 ch 7.
- ch_mask=8'h00 (and separately stack_mask=0).
  - Required: no rd_start_o; ack_o pulses; busy_o is high for at most 3 cycles; no valid_o.
- req_i pulsed mid-readout with different masks, plus spurious rd_valid_i on an unselected stack.
  - Required: the request is ignored; the output stream is unaffected.
- rst_n_i low during WAIT_DONE of stack 2.
  - Required: all outputs 0 asynchronously; no ack_o; a new request afterwards completes normally.
- IRS_READOUT_TIMEOUT_EN defined, TIMEOUT_CYCLES=100; stack 1 model never asserts done.
  - Required: err_o=1 after the stall; stacks 2 and 3 are still read.
  - Required: ack_o pulses; err_o clears on the next request.
